// File: rtl/dense_result_collector.sv
// -----------------------------------------------------------------------------
// dense_result_collector
//
// Collects the paired result lanes of mul_dense (two adjacent columns of C per
// beat) into a show-ahead pair FIFO, then serialises them as a single 64-bit
// ready/valid element stream tagged with row/column indices. mul_dense cannot
// be stalled, so beats that find no room (or arrive while not armed) are
// dropped and recorded in a sticky overflow flag.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      one-cycle pulse: flush FIFO, clear indices/overflow, arm
//   in_valid   mul_dense beat valid
//   in_data1   C[r][c]   (even column)
//   in_data2   C[r][c+1] (odd column)
//   out_data   current element
//   out_valid  out_data/out_row/out_col/out_last valid
//   out_ready  downstream accepts element
//   out_row    row index of out_data
//   out_col    column index of out_data
//   out_last   element is C[ROWS-1][COLS-1]
//   busy       armed, matrix not yet fully emitted
//   done       one-cycle pulse after the last element transfers
//   overflow   sticky: an input beat was dropped
//   level      FIFO occupancy in pairs
// -----------------------------------------------------------------------------
module dense_result_collector #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DEPTH = 8,
  parameter int IDX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [63:0]              in_data1,
  input  logic [63:0]              in_data2,
  output logic [63:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_row,
  output logic [IDX_W-1:0]         out_col,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(COLS - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [127:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic [IDX_W-1:0]   r_row;
  logic [IDX_W-1:0]   r_col;
  logic               r_done;
  logic               r_overflow;

  logic [127:0]       w_head;
  logic               w_busy;
  logic               w_out_valid;
  logic               w_xfer;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               w_last;
  logic [PTR_W-1:0]   w_wr_addr;

  // ---------------------------------------------------------------------------
  // Handshake and FIFO control
  // ---------------------------------------------------------------------------
  assign w_head      = r_mem[r_rd_ptr];
  assign w_busy      = (r_state != ST_IDLE);
  assign w_out_valid = w_busy && (r_level != '0);
  assign w_last      = (r_row == LAST_ROW) && (r_col == LAST_COL);

  // A transfer coinciding with start belongs to the aborted matrix and is
  // discarded by the flush, so it must not advance anything.
  assign w_xfer = w_out_valid && out_ready && !start;
  assign w_pop  = w_xfer && (r_state == ST_HI);

  // start flushes the FIFO, so a beat arriving with it always has room and
  // becomes the first pair of the new matrix.
  assign w_push = in_valid && (start || (w_busy && ((r_level < FULL_LVL) || w_pop)));
  assign w_drop = in_valid && !w_push;

  assign w_wr_addr = start ? '0 : r_wr_ptr;

  // ---------------------------------------------------------------------------
  // FSM: IDLE -> LO (even column) -> HI (odd column) -> LO ... -> IDLE
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // NOTE: the default on the first line keeps every path assigned, so no
  // latch is inferred when a branch leaves the state unchanged.
  always_comb begin
    w_next_state = r_state;
    if (start) begin
      w_next_state = ST_LO;
    end else begin
      unique case (r_state)
        ST_IDLE: w_next_state = ST_IDLE;
        ST_LO:   if (w_xfer) w_next_state = ST_HI;
        ST_HI:   if (w_xfer) w_next_state = w_last ? ST_IDLE : ST_LO;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pair storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; stale contents are never visible
  // because out_data is gated by out_valid, which needs a non-zero level.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_wr_addr] <= {in_data2, in_data1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (start) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= w_push ? PTR_W'(1) : '0;
      r_level  <= w_push ? LVL_W'(1) : '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Element indices, done pulse and sticky overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row      <= '0;
      r_col      <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= w_xfer && w_last;

      if (start)       r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;

      if (start) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_xfer) begin
        if (r_col == LAST_COL) begin
          r_col <= '0;
          // Wrapping the row after the last element leaves the indices at 0
          // while idle.
          r_row <= w_last ? '0 : r_row + IDX_W'(1);
        end else begin
          r_col <= r_col + IDX_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid = w_out_valid;
  assign out_data  = !w_out_valid          ? '0            :
                     (r_state == ST_HI)    ? w_head[127:64] : w_head[63:0];
  assign out_row   = r_row;
  assign out_col   = r_col;
  assign out_last  = w_last;
  assign busy      = w_busy;
  assign done      = r_done;
  assign overflow  = r_overflow;
  assign level     = r_level;

endmodule

// File: doc/dense_result_collector.md
Name: dense_result_collector

Overview:
- Downstream stage of mul_dense. Captures its two 64-bit result lanes (dataout1, dataout2, qualified by valid) into a pair FIFO.
- Serialises the FIFO contents into a single 64-bit ready/valid element stream, tagged with row/column indices, so result matrix C can be written back or checked element by element.
- mul_dense has no backpressure, so this block absorbs bursts and flags any loss.

Parameters:
- ROWS, 4, rows of result matrix C (>=1)
- COLS, 4, columns of C (even, >=2); each input beat carries two adjacent columns
- DEPTH, 8, FIFO depth in pair entries (power of two, >=2)
- IDX_W, 8, width of row/col index outputs (must cover max(ROWS,COLS)-1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse: flush FIFO, clear counters/overflow, arm for one matrix
- in_valid  input  1  mul_dense valid
- in_data1  input  64  mul_dense dataout1 = C[r][c] (even column)
- in_data2  input  64  mul_dense dataout2 = C[r][c+1]
- out_data  output  64  current element
- out_valid  output  1  out_data/out_row/out_col/out_last valid
- out_ready  input  1  downstream accepts element
- out_row  output  IDX_W  row index of out_data
- out_col  output  IDX_W  column index of out_data
- out_last  output  1  element is C[ROWS-1][COLS-1]
- busy  output  1  armed, matrix not yet fully emitted
- done  output  1  one-cycle pulse after the last element transfers
- overflow  output  1  sticky: an input beat was dropped
- level  output  $clog2(DEPTH)+1  FIFO occupancy in pairs

Behaviour:
- Reset (rst=0, async): all outputs 0, FIFO empty, state IDLE, indices 0. No X on any output after reset.
- Reset asserted mid-matrix aborts immediately. Nothing is emitted until the next start.
- States:
  - IDLE: busy=0. start moves to LO.
  - LO: emit in_data1 of the head pair. On transfer, move to HI.
  - HI: emit in_data2 of the head pair. On transfer, pop the head; go to IDLE if out_last, else LO.
- out_valid = (state LO or HI) and FIFO non-empty.
- Transfer = out_valid & out_ready.
- While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last hold stable.
- Indices:
  - out_col increments on every transfer, wraps COLS-1 -> 0, and out_row increments on the wrap.
  - out_last = (out_row==ROWS-1) & (out_col==COLS-1).
  - Indices reset to 0 on start.
- done: single-cycle pulse in the cycle after the out_last transfer. busy falls in the same cycle.
- Latency: FIFO is show-ahead. in_valid at edge t into an empty FIFO in LO gives out_valid=1 after edge t (visible cycle t+1).
- Push rules:
  - A push is accepted when in_valid & busy & (level<DEPTH, or a HI transfer pops in the same cycle).
  - Simultaneous push and pop leaves level unchanged.
  - A beat with in_valid=1 while full (no pop) is dropped and sets overflow=1.
  - A beat with in_valid=1 while not busy is dropped and sets overflow=1.
  - Dropped beats never alter indices.
  - overflow clears only on start or reset.
- Extra beats beyond ROWS*COLS/2 are accepted into the FIFO if space allows. They are discarded by the flush on the next start and never emitted.
- start while busy: restart. FIFO flushed, indices 0, state LO, overflow cleared. An in_valid in the same cycle as start is accepted as the first pair of the new matrix.
- level: registered count, 0..DEPTH, updated every edge.

Test Plan:
- Test configuration for all scenarios: ROWS=2, COLS=4, DEPTH=4, IDX_W=8.
- Basic: start; 4 beats (1,2),(3,4),(5,6),(7,8); out_ready=1 → out_data 1..8 in order, (row,col) (0,0)..(1,3), out_last only on 8, done pulses once, busy=0 afterwards, overflow=0.
- Backpressure: same input; out_ready toggles 1,0,0,1... → identical 8-element sequence, outputs stable during each stall, level never exceeds 4.
- Overflow: out_ready=0; 5 consecutive beats (10,11)..(18,19) → level=4, overflow=1 from the 5th beat. After out_ready=1, elements 10..17 are emitted and (18,19) is never emitted.
- Full with simultaneous pop: level=4, HI transfer and in_valid in the same cycle → beat accepted, level stays 4, overflow=0.
- Restart and idle drop: start, 1 beat, then start again, then 4 beats (21..28) → only 21..28 emitted, indices restart at (0,0). A later in_valid while busy=0 sets overflow=1 and nothing is emitted.
- Async reset: rst low mid-stream (between clock edges) → all outputs 0 immediately. After rst high, no out_valid until start.
